// File: rtl/serial_cmd_dispatcher.sv
// UART packet assembler and command dispatcher for the serial pattern channels.
// Collects 9-byte packets, issues start/stop strobes and a one-byte ACK/NAK reply.
module serial_cmd_dispatcher #(
    parameter int         DATA_BIT    = 32,
    parameter int         PACK_NUM    = 9,
    parameter int         CH_NUM      = 16,
    parameter int         TIMEOUT_CLK = 20000,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter logic [7:0] NAK_BYTE    = 8'hEE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done_tick,
    input  logic [CH_NUM-1:0]   i_ch_busy,
    input  logic                i_tx_done_tick,
    output logic [DATA_BIT-1:0] o_out_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic                o_mode,
    output logic [CH_NUM-1:0]   o_start_tick,
    output logic [CH_NUM-1:0]   o_stop_tick,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    output logic                o_timeout_tick
);

    localparam int SW   = 2 * DATA_BIT;
    localparam int CNTW = $clog2(PACK_NUM);
    localparam int TW   = $clog2(TIMEOUT_CLK);
    localparam int CHW  = $clog2(CH_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPATCH
    } state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [SW-1:0]       shadow_q, shadow_d;
    logic                pend_q, pend_d;
    logic [DATA_BIT-1:0] outp_q, outp_d;
    logic [DATA_BIT-1:0] freq_q, freq_d;
    logic                mode_q, mode_d;
    logic [CH_NUM-1:0]   start_q, start_d;
    logic [CH_NUM-1:0]   stop_q, stop_d;
    logic                txs_q, txs_d;
    logic [7:0]          txd_q, txd_d;
    logic                tmo_tick_q, tmo_tick_d;

    logic                last_byte;
    logic                expire;
    logic                ok;
    logic [CHW-1:0]      ch;
    logic [1:0]          cmd;
    logic [CH_NUM-1:0]   one_hot;

    assign ch      = i_rx_data[7:4];
    assign cmd     = i_rx_data[1:0];
    assign one_hot = {{(CH_NUM-1){1'b0}}, 1'b1} << ch;

    assign last_byte = (state_q == S_COLLECT) && i_rx_done_tick
                       && (cnt_q == CNTW'(PACK_NUM - 1));
    // An arriving byte always beats the timeout in the same cycle
    assign expire    = (state_q == S_COLLECT) && !i_rx_done_tick
                       && (tmo_q == TW'(TIMEOUT_CLK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= 1'b0;
            outp_q     <= '0;
            freq_q     <= '0;
            mode_q     <= 1'b0;
            start_q    <= '0;
            stop_q     <= '0;
            txs_q      <= 1'b0;
            txd_q      <= '0;
            tmo_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            outp_q     <= outp_d;
            freq_q     <= freq_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            txs_q      <= txs_d;
            txd_q      <= txd_d;
            tmo_tick_q <= tmo_tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        unique case (state_q)
            S_IDLE, S_DISPATCH: begin
                tmo_d = '0;
                if (i_rx_done_tick) begin
                    shadow_d = {i_rx_data, shadow_q[SW-1:8]};
                    cnt_d    = CNTW'(1);
                    state_d  = S_COLLECT;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (i_rx_done_tick) begin
                    tmo_d = '0;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = S_DISPATCH;
                    end else begin
                        shadow_d = {i_rx_data, shadow_q[SW-1:8]};
                        cnt_d    = cnt_q + CNTW'(1);
                    end
                end else if (expire) begin
                    tmo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase
    end

    always_comb begin
        start_d    = '0;
        stop_d     = '0;
        txs_d      = 1'b0;
        txd_d      = txd_q;
        outp_d     = outp_q;
        freq_d     = freq_q;
        mode_d     = mode_q;
        tmo_tick_d = expire;
        ok         = 1'b0;
        if (last_byte) begin
            unique case (1'b1)
                cmd == 2'b01: begin
                    if (!i_ch_busy[ch]) begin
                        start_d = one_hot;
                        outp_d  = shadow_q[DATA_BIT-1:0];
                        freq_d  = shadow_q[SW-1:DATA_BIT];
                        mode_d  = i_rx_data[2];
                        ok      = 1'b1;
                    end
                end
                cmd == 2'b10: begin
                    stop_d = one_hot;
                    ok     = 1'b1;
                end
                cmd == 2'b11: begin
                    stop_d = '1;
                    ok     = 1'b1;
                end
                default: ok = 1'b0;
            endcase
            if (!pend_q) begin
                txs_d = 1'b1;
                txd_d = ok ? ACK_BYTE : NAK_BYTE;
            end
        end
        // A done tick coinciding with a fresh request does not clear it
        pend_d = txs_d | (pend_q & ~(i_tx_done_tick & ~txs_q));
    end

    assign o_out_pattern  = outp_q;
    assign o_freq_pattern = freq_q;
    assign o_mode         = mode_q;
    assign o_start_tick   = start_q;
    assign o_stop_tick    = stop_q;
    assign o_tx_start     = txs_q;
    assign o_tx_data      = txd_q;
    assign o_timeout_tick = tmo_tick_q;

endmodule

// File: tb/tb_serial_cmd_dispatcher.sv
// Bench for serial_cmd_dispatcher: packet vector table with an expectation queue,
// plus timeout, reset, back-to-back and reply-flag corner sequences.
module tb_serial_cmd_dispatcher;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_tick;
    logic [15:0] ch_busy;
    logic        tx_done;
    logic [31:0] o_out_pattern;
    logic [31:0] o_freq_pattern;
    logic        o_mode;
    logic [15:0] o_start_tick;
    logic [15:0] o_stop_tick;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_timeout_tick;

    serial_cmd_dispatcher #(.TIMEOUT_CLK(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_data      (rx_data),
        .i_rx_done_tick (rx_tick),
        .i_ch_busy      (ch_busy),
        .i_tx_done_tick (tx_done),
        .o_out_pattern  (o_out_pattern),
        .o_freq_pattern (o_freq_pattern),
        .o_mode         (o_mode),
        .o_start_tick   (o_start_tick),
        .o_stop_tick    (o_stop_tick),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_timeout_tick (o_timeout_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] st;
        logic [15:0] sp;
        logic        txs;
        logic [7:0]  txd;
        logic [31:0] eo;
        logic [31:0] ef;
        logic        m;
    } exp_t;

    typedef struct {
        logic [31:0] o;
        logic [31:0] f;
        logic [7:0]  c;
        logic [15:0] b;
        logic        d;
        int          g;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   nv = 0;
    int   nf = 0;
    int   n_act = 0;
    int   exp_act = 0;
    int   n_tmo = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (|o_start_tick || |o_stop_tick || o_tx_start)
                n_act <= n_act + 1;
            if (o_timeout_tick)
                n_tmo <= n_tmo + 1;
        end
    end

    function automatic vec_t mk(
        input logic [31:0] o, input logic [31:0] f,
        input logic [7:0] c, input logic [15:0] b,
        input logic d, input int g,
        input logic [15:0] st, input logic [15:0] sp,
        input logic txs, input logic [7:0] txd,
        input logic [31:0] eo, input logic [31:0] ef,
        input logic m);
        vec_t v;
        v.o = o; v.f = f; v.c = c; v.b = b; v.d = d; v.g = g;
        v.e.st = st; v.e.sp = sp; v.e.txs = txs; v.e.txd = txd;
        v.e.eo = eo; v.e.ef = ef; v.e.m = m;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        nv++;
        if (act !== req) begin
            nf++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data = b;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v, input int sidx, input int slen);
        logic [71:0] bytes;
        exp_t        e;
        bytes   = {v.c, v.f, v.o};
        ch_busy = v.b;
        sb.push_back(v.e);
        if (v.e.st != 0 || v.e.sp != 0 || v.e.txs)
            exp_act++;
        for (int k = 0; k < 9; k++) begin
            if (k == sidx)
                repeat (slen) @(negedge clk);
            else if (k > 0)
                repeat (v.g) @(negedge clk);
            put_byte(bytes[8*k +: 8]);
        end
        e = sb.pop_front();
        chk($sformatf("start c=%h", v.c), 64'(o_start_tick), 64'(e.st));
        chk($sformatf("stop c=%h", v.c), 64'(o_stop_tick), 64'(e.sp));
        chk($sformatf("txs c=%h", v.c), 64'(o_tx_start), 64'(e.txs));
        if (e.txs)
            chk($sformatf("txd c=%h", v.c), 64'(o_tx_data), 64'(e.txd));
        chk($sformatf("outp c=%h", v.c), 64'(o_out_pattern), 64'(e.eo));
        chk($sformatf("freq c=%h", v.c), 64'(o_freq_pattern), 64'(e.ef));
        chk($sformatf("mode c=%h", v.c), 64'(o_mode), 64'(e.m));
        chk($sformatf("tmo c=%h", v.c), 64'(o_timeout_tick), 64'(0));
        if (v.d)
            pulse_done();
    endtask

    initial begin
        int c;
        tbl[0]  = mk(32'h00550055, 32'h0, 8'h01, 16'h0000, 1, 0,
                     16'h0001, 16'h0, 1, 8'hA5, 32'h00550055, 32'h0, 0);
        tbl[1]  = mk(32'h12345678, 32'hCAFEBABE, 8'h55, 16'h0020, 1, 2,
                     16'h0, 16'h0, 1, 8'hEE, 32'h00550055, 32'h0, 0);
        tbl[2]  = mk(32'h0, 32'h0, 8'h52, 16'h0020, 1, 0,
                     16'h0, 16'h0020, 1, 8'hA5, 32'h00550055, 32'h0, 0);
        tbl[3]  = mk(32'h0, 32'h0, 8'h03, 16'h0000, 1, 1,
                     16'h0, 16'hFFFF, 1, 8'hA5, 32'h00550055, 32'h0, 0);
        tbl[4]  = mk(32'h0, 32'h0, 8'h00, 16'h0000, 1, 0,
                     16'h0, 16'h0, 1, 8'hEE, 32'h00550055, 32'h0, 0);
        tbl[5]  = mk(32'hDEADBEEF, 32'h0F0F0F0F, 8'h3D, 16'hFFF7, 1, 3,
                     16'h0008, 16'h0, 1, 8'hA5, 32'hDEADBEEF, 32'h0F0F0F0F, 1);
        tbl[6]  = mk(32'hA1B2C3D4, 32'h11223344, 8'hF1, 16'h0000, 0, 0,
                     16'h8000, 16'h0, 1, 8'hA5, 32'hA1B2C3D4, 32'h11223344, 0);
        tbl[7]  = mk(32'h0, 32'h0, 8'hE2, 16'h4000, 0, 0,
                     16'h0, 16'h4000, 0, 8'h00, 32'hA1B2C3D4, 32'h11223344, 0);
        tbl[8]  = mk(32'h87654321, 32'hFFFF0000, 8'h71, 16'h0000, 1, 0,
                     16'h0080, 16'h0, 0, 8'h00, 32'h87654321, 32'hFFFF0000, 0);
        tbl[9]  = mk(32'h0, 32'h0, 8'h23, 16'h0000, 1, 1,
                     16'h0, 16'hFFFF, 1, 8'hA5, 32'h87654321, 32'hFFFF0000, 0);
        tbl[10] = mk(32'h5A5A5A5A, 32'h0, 8'h65, 16'h0040, 1, 0,
                     16'h0, 16'h0, 1, 8'hEE, 32'h87654321, 32'hFFFF0000, 0);

        rst     = 1'b1;
        rx_data = '0;
        rx_tick = 1'b0;
        ch_busy = '0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pat", {o_out_pattern, o_freq_pattern}, 64'(0));
        chk("reset_ctl", 64'({o_mode, o_start_tick, o_stop_tick,
                              o_tx_start, o_tx_data, o_timeout_tick}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            send_pkt(tbl[i], -1, 0);

        // partial packet then idle until the timeout fires
        for (int k = 0; k < 5; k++)
            put_byte(8'h10 + 8'(k));
        c = 0;
        while (!o_timeout_tick && c < 3 * T) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("tmo_latency", 64'(c), 64'(T));
        @(negedge clk);
        send_pkt(mk(32'h01020304, 32'hAAAA5555, 8'h91, 16'hFDFF, 1, 0,
                    16'h0200, 16'h0, 1, 8'hA5, 32'h01020304, 32'hAAAA5555, 0),
                 -1, 0);

        // byte arriving on the expiry cycle is kept
        send_pkt(mk(32'h0BADF00D, 32'h76543210, 8'hA1, 16'h0000, 1, 0,
                    16'h0400, 16'h0, 1, 8'hA5, 32'h0BADF00D, 32'h76543210, 0),
                 3, T - 1);

        // reset in the middle of a packet
        for (int k = 0; k < 6; k++)
            put_byte(8'h77);
        rst = 1'b1;
        #1;
        chk("midrst_pat", {o_out_pattern, o_freq_pattern}, 64'(0));
        chk("midrst_ctl", 64'({o_mode, o_start_tick, o_stop_tick,
                               o_tx_start, o_tx_data, o_timeout_tick}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_pkt(mk(32'hFEEDFACE, 32'h00FF00FF, 8'h25, 16'h0000, 1, 1,
                    16'h0004, 16'h0, 1, 8'hA5, 32'hFEEDFACE, 32'h00FF00FF, 1),
                 -1, 0);

        // done tick in the same cycle as a new request keeps the flag set
        send_pkt(mk(32'h0, 32'h0, 8'h12, 16'h0000, 0, 0,
                    16'h0, 16'h0002, 1, 8'hA5, 32'hFEEDFACE, 32'h00FF00FF, 1),
                 -1, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        send_pkt(mk(32'h0, 32'h0, 8'h13, 16'h0000, 1, 0,
                    16'h0, 16'hFFFF, 0, 8'h00, 32'hFEEDFACE, 32'h00FF00FF, 1),
                 -1, 0);
        send_pkt(mk(32'h0, 32'h0, 8'h42, 16'h0000, 1, 0,
                    16'h0, 16'h0010, 1, 8'hA5, 32'hFEEDFACE, 32'h00FF00FF, 1),
                 -1, 0);

        repeat (4) @(negedge clk);
        chk("active_cycles", 64'(n_act), 64'(exp_act));
        chk("timeout_count", 64'(n_tmo), 64'(1));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end

endmodule
